cnn_window_gen: RTL and testbench
=================================

# cnn_window_gen

Streaming sliding-window generator that sits directly upstream of the per-kernel multiply-accumulate stage. Accepts one raster-ordered input feature-map pixel per valid cycle, buffers KY-1 full rows, and emits every valid (unpadded, stride-1) KX×KY window as a flat vector. The vector is packed exactly as the kernel stage's `f_map_i` expects, so the two blocks connect with no glue logic.

## Interface
- KX, default 3 (shared core defines): window width in columns
- KY, default 3 (shared core defines): window height in rows
- I_F_BW, default 8 (shared core defines): pixel width in bits
- IX, default 8: image width in pixels; must satisfy IX ≥ KX
- IY, default 8: image height in rows; must satisfy IY ≥ KY

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- soft_reset_i  in  1  synchronous clear; has priority over every other input
- in_valid_i  in  1  marks in_pixel_i valid this cycle
- in_pixel_i  in  I_F_BW  unsigned input pixel, raster order (row-major, column 0 first)
- ot_valid_o  out  1  ot_f_map_o holds a new window this cycle (1-cycle pulse per window)
- ot_f_map_o  out  KX*KY*I_F_BW  window; element (x,y) at bits [(KY*x+y)*I_F_BW +: I_F_BW]
- ot_done_o  out  1  1-cycle pulse coincident with the last window of an image

## Operation
- Counters: col_cnt in 0..IX-1 and row_cnt in 0..IY-1 give the position of the next pixel. Each is clog2 wide, minimum 1 bit.
- Each accepted pixel (in_valid_i=1) advances col_cnt. At col IX-1, col_cnt wraps to 0 and row_cnt increments. At (IY-1, IX-1), both wrap to 0 and the next pixel starts a new image with no idle cycle.
- Cycles with in_valid_i=0 leave all state unchanged: counters, line buffers and window.
- Line buffers: KY-1 delay lines of IX pixels each, advanced only on accepted pixels. Together with the incoming pixel they give a vertical column of KY pixels from rows r-KY+1..r at the current column.
- Window register: KX columns of KY pixels. On each accepted pixel, columns shift toward x=0 and the new vertical column enters at x=KX-1.
- Element coordinates: x=0 is the leftmost (oldest) column; y=0 is the top (oldest) row. So element (x,y) = pixel[r-KY+1+y][c-KX+1+x], where (r,c) is the pixel just accepted.
- Phases:
  - FILL: row_cnt < KY-1. Pixels are buffered and no window is emitted.
  - RUN: row_cnt ≥ KY-1. A window is emitted for each accepted pixel with col_cnt ≥ KX-1.
  - The phase is derived from row_cnt; there is no separate state register.
- Windows per image: (IX-KX+1)*(IY-KY+1). No window ever straddles a row boundary or an image boundary.
- Line-buffer and window contents are don't-care after reset or soft reset. Windows are emitted only after KY-1 rows of the current image have been accepted.
- Reset and soft reset behaviour:
  - soft_reset_i=1 clears col_cnt, row_cnt, ot_valid_o, ot_done_o and ot_f_map_o. Any pixel presented in the same cycle is dropped.
  - reset_n low clears the same state asynchronously.
  - In either case a partially received image is abandoned and the next accepted pixel is treated as (0,0).

## Timing
- Reset value of every output: ot_valid_o=0, ot_done_o=0, ot_f_map_o=0.
- Latency is 1 cycle. A window-completing pixel accepted at edge N drives ot_valid_o=1 and the window on ot_f_map_o during cycle N+1.
- ot_valid_o is high for exactly one cycle per window. Back-to-back input gives back-to-back windows.
- ot_f_map_o is registered and holds its last value while ot_valid_o=0.
- ot_done_o=1 only in the cycle where ot_valid_o carries the window completed by pixel (IY-1, IX-1).
- No backpressure: the downstream stage must accept every ot_valid_o pulse.

## Test plan
- Basic image: IX=IY=4, KX=KY=3, pixels 1..16 back-to-back.
  - Exactly 4 windows, on the cycles after pixels 11, 12, 15 and 16.
  - First window elements at indices 0..8 = 1,5,9,2,6,10,3,7,11.
  - ot_done_o only with the 4th window, whose elements = 6,10,14,7,11,15,8,12,16.
- Gapped input: same image with in_valid_i toggled 1,0,1,0…
  - Windows are identical and in the same order.
  - Each window appears 1 cycle after its completing pixel; ot_valid_o stays 0 in gap cycles.
- Back-to-back images: pixels 1..16, then 101..116, with no idle cycle.
  - 8 windows total; the first window of image 2 = 101,105,109,102,106,110,103,107,111.
  - ot_done_o pulses twice; no window mixes pixels from the two images.
- Soft reset mid-image: assert soft_reset_i for 1 cycle after pixel 10, then send 1..16.
  - Outputs read 0 the cycle after the soft reset, and no window comes from the partial image.
  - The new image produces exactly the basic-image sequence.
- Async reset: drop reset_n mid-cycle after pixel 12.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a full image reproduces the basic-image result.
- Parameter corner: IX=KX=3, IY=KY=3, pixels 1..9 → one window 1,4,7,2,5,8,3,6,9, with ot_valid_o and ot_done_o both high in the same cycle.

Source files
------------

// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out stream bundle between a raster pixel source,
// the window generator and the downstream kernel stage.
interface cnn_window_gen_if #(
    parameter int unsigned KX     = 3,
    parameter int unsigned KY     = 3,
    parameter int unsigned I_F_BW = 8
);
    logic                       soft_reset_i;
    logic                       in_valid_i;
    logic [I_F_BW-1:0]          in_pixel_i;
    logic                       ot_valid_o;
    logic [KX*KY*I_F_BW-1:0]    ot_f_map_o;
    logic                       ot_done_o;

    modport master (
        output soft_reset_i,
        output in_valid_i,
        output in_pixel_i,
        input  ot_valid_o,
        input  ot_f_map_o,
        input  ot_done_o
    );

    modport slave (
        input  soft_reset_i,
        input  in_valid_i,
        input  in_pixel_i,
        output ot_valid_o,
        output ot_f_map_o,
        output ot_done_o
    );
endinterface

// File: rtl/cnn_window_gen.sv
// Streaming KX x KY sliding-window generator: raster pixels in, one packed
// window per valid position out, one cycle after the completing pixel.
module cnn_window_gen #(
    parameter int unsigned KX     = 3,
    parameter int unsigned KY     = 3,
    parameter int unsigned I_F_BW = 8,
    parameter int unsigned IX     = 8,
    parameter int unsigned IY     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    cnn_window_gen_if.slave  if_s
);
    localparam int unsigned CW  = (IX > 1) ? $clog2(IX) : 1;
    localparam int unsigned RW  = (IY > 1) ? $clog2(IY) : 1;
    localparam int unsigned NLB = (KY > 1) ? KY - 1 : 1;
    localparam int unsigned FW  = KX * KY * I_F_BW;

    typedef logic [I_F_BW-1:0] pix_t;

    logic [CW-1:0] r_col_cnt;
    logic [RW-1:0] r_row_cnt;
    logic          r_valid;
    logic          r_done;
    logic [FW-1:0] r_f_map;

    pix_t          r_lb      [NLB][IX];
    pix_t          w_lb_nxt  [NLB][IX];
    pix_t          r_win     [KX][KY];
    pix_t          w_win_nxt [KX][KY];
    pix_t          w_vcol    [KY];
    logic [FW-1:0] w_f_map_nxt;

    logic w_acc;
    logic w_col_last;
    logic w_row_last;
    logic w_run;
    logic w_emit;
    logic w_done;

    // Soft reset drops any pixel presented alongside it.
    assign w_acc      = if_s.in_valid_i & ~if_s.soft_reset_i;
    assign w_col_last = (r_col_cnt == CW'(IX - 1));
    assign w_row_last = (r_row_cnt == RW'(IY - 1));
    assign w_run      = (r_row_cnt >= RW'(KY - 1));
    assign w_emit     = w_acc & w_run & (r_col_cnt >= CW'(KX - 1));
    assign w_done     = w_emit & w_col_last & w_row_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (if_s.soft_reset_i) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (if_s.in_valid_i) begin
            if (w_col_last) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_f_map <= '0;
        end else if (if_s.soft_reset_i) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_f_map <= '0;
        end else begin
            r_valid <= w_emit;
            r_done  <= w_done;
            if (w_emit) begin
                r_f_map <= w_f_map_nxt;
            end
        end
    end

    // Line k delays by (k+1) rows; its tail is the pixel k+1 rows above.
    for (genvar k = 0; k < NLB; k++) begin : g_lb_line
        for (genvar i = 0; i < IX; i++) begin : g_lb_tap
            if (i == 0) begin : g_head
                if (k == 0) begin : g_first
                    assign w_lb_nxt[k][i] = if_s.in_pixel_i;
                end else begin : g_chain
                    assign w_lb_nxt[k][i] = r_lb[k-1][IX-1];
                end
            end else begin : g_body
                assign w_lb_nxt[k][i] = r_lb[k][i-1];
            end
        end
    end

    // Vertical column for the current column: y=KY-1 is the new pixel.
    assign w_vcol[KY-1] = if_s.in_pixel_i;
    for (genvar k = 0; k < KY - 1; k++) begin : g_vcol
        assign w_vcol[KY-2-k] = r_lb[k][IX-1];
    end

    for (genvar x = 0; x < KX; x++) begin : g_win_x
        for (genvar y = 0; y < KY; y++) begin : g_win_y
            if (x == KX - 1) begin : g_new
                assign w_win_nxt[x][y] = w_vcol[y];
            end else begin : g_shift
                assign w_win_nxt[x][y] = r_win[x+1][y];
            end
            assign w_f_map_nxt[(KY*x+y)*I_F_BW +: I_F_BW] = w_win_nxt[x][y];
        end
    end

    // Data path carries no reset: its contents are don't-care until refilled.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb  <= w_lb_nxt;
            r_win <= w_win_nxt;
        end
    end

    assign if_s.ot_valid_o = r_valid;
    assign if_s.ot_done_o  = r_done;
    assign if_s.ot_f_map_o = r_f_map;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench: a 4x4 and a 3x3 image instance of cnn_window_gen with
// 3x3 kernels, driven by directed pixel sequences.
module tb_cnn_window_gen;
    localparam int W  = 8;
    localparam int FW = 9 * W;

    typedef struct {
        logic [FW-1:0] fmap;
        logic          done;
        int            cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   seen [2];
    int   mr   [2];
    int   mc   [2];
    logic [W-1:0] img [2][4][4];
    exp_t q_a [$];
    exp_t q_b [$];

    cnn_window_gen_if #(.KX(3), .KY(3), .I_F_BW(W)) a_if ();
    cnn_window_gen_if #(.KX(3), .KY(3), .I_F_BW(W)) b_if ();

    cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(W), .IX(4), .IY(4)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .if_s    (a_if)
    );

    cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(W), .IX(3), .IY(3)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .if_s    (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [FW-1:0] f, input logic dn);
        exp_t e;
        if (v) begin
            seen[d]++;
            if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                check($sformatf("dut%0d unexpected window", d), 1'b1, 1'b0);
            end else begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                check($sformatf("dut%0d window data", d), f, e.fmap);
                check($sformatf("dut%0d done flag", d), FW'(dn), FW'(e.done));
                check($sformatf("dut%0d window cycle", d), FW'(cyc), FW'(e.cyc));
            end
        end else if (dn) begin
            check($sformatf("dut%0d done without valid", d), 1'b1, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, a_if.ot_valid_o, a_if.ot_f_map_o, a_if.ot_done_o);
            mon(1, b_if.ot_valid_o, b_if.ot_f_map_o, b_if.ot_done_o);
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input int d, input logic v, input logic [W-1:0] p, input logic sr);
        int            dim;
        exp_t          e;
        logic [FW-1:0] f;
        dim = (d == 0) ? 4 : 3;
        if (d == 0) begin
            a_if.in_valid_i = v; a_if.in_pixel_i = p; a_if.soft_reset_i = sr;
        end else begin
            b_if.in_valid_i = v; b_if.in_pixel_i = p; b_if.soft_reset_i = sr;
        end
        if (sr) begin
            mr[d] = 0; mc[d] = 0;
        end else if (v) begin
            img[d][mr[d]][mc[d]] = p;
            if (mr[d] >= 2 && mc[d] >= 2) begin
                f = '0;
                for (int x = 0; x < 3; x++)
                    for (int y = 0; y < 3; y++)
                        f[(3*x+y)*W +: W] = img[d][mr[d]-2+y][mc[d]-2+x];
                e.fmap = f;
                e.done = (mr[d] == dim - 1) && (mc[d] == dim - 1);
                e.cyc  = cyc + 1;
                if (d == 0) q_a.push_back(e); else q_b.push_back(e);
            end
            if (mc[d] == dim - 1) begin
                mc[d] = 0;
                mr[d] = (mr[d] == dim - 1) ? 0 : mr[d] + 1;
            end else begin
                mc[d]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) drive(d, 1'b0, '0, 1'b0);
    endtask

    task automatic expect_count(input int d, input int n, input string name);
        check({name, " window count"}, FW'(seen[d]), FW'(n));
        check({name, " queue drained"}, FW'((d == 0) ? q_a.size() : q_b.size()), '0);
        seen[d] = 0;
    endtask

    task automatic check_zero(input int d, input string name);
        if (d == 0) begin
            check({name, " valid"}, FW'(a_if.ot_valid_o), '0);
            check({name, " done"}, FW'(a_if.ot_done_o), '0);
            check({name, " f_map"}, a_if.ot_f_map_o, '0);
        end else begin
            check({name, " valid"}, FW'(b_if.ot_valid_o), '0);
            check({name, " done"}, FW'(b_if.ot_done_o), '0);
            check({name, " f_map"}, b_if.ot_f_map_o, '0);
        end
    endtask

    task automatic send_image(input int d, input int n, input int base);
        for (int p = 1; p <= n; p++) drive(d, 1'b1, W'(base + p), 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        seen = '{0, 0}; mr = '{0, 0}; mc = '{0, 0};
        a_if.in_valid_i = 1'b0; a_if.in_pixel_i = '0; a_if.soft_reset_i = 1'b0;
        b_if.in_valid_i = 1'b0; b_if.in_pixel_i = '0; b_if.soft_reset_i = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #11;
        check_zero(0, "reset a");
        check_zero(1, "reset b");
        @(negedge clk);
        reset_n = 1'b1;

        send_image(0, 16, 0);
        idle(0, 3);
        expect_count(0, 4, "basic");

        for (int p = 1; p <= 16; p++) begin
            drive(0, 1'b1, W'(p), 1'b0);
            drive(0, 1'b0, '0, 1'b0);
        end
        idle(0, 2);
        expect_count(0, 4, "gapped");

        send_image(0, 16, 0);
        send_image(0, 16, 100);
        idle(0, 3);
        expect_count(0, 8, "back-to-back");

        send_image(0, 10, 0);
        drive(0, 1'b1, 8'd99, 1'b1);
        check_zero(0, "after soft reset");
        send_image(0, 16, 0);
        idle(0, 3);
        expect_count(0, 4, "soft reset");

        send_image(0, 12, 0);
        a_if.in_valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_zero(0, "async reset a");
        check_zero(1, "async reset b");
        expect_count(0, 2, "pre-reset");
        mr = '{0, 0}; mc = '{0, 0};
        @(negedge clk);
        reset_n = 1'b1;
        send_image(0, 16, 0);
        idle(0, 3);
        expect_count(0, 4, "after async reset");

        send_image(1, 9, 0);
        idle(1, 3);
        expect_count(1, 1, "corner");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
